// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 16-bit words from program memory and hands
// them one at a time to a CPU through a load/start/wait handshake, with a
// per-phase timeout, a sticky DONE/ERROR state and abort.
module instr_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       cpu_in,
  output logic              cpu_load,
  output logic              cpu_s,
  input  logic              cpu_w,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       icount
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, ISSUE, EXEC_LO, EXEC_HI, DONE, ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     ir;
  logic [TW-1:0]   tcnt;
  logic            is_halt;
  logic            go;
  logic            last;
  logic            tmo;

  assign is_halt   = (imem_data[15:13] == 3'b111);
  assign go        = start && cpu_w;
  assign last      = (pc == '1);
  assign tmo       = (tcnt == TW'(TIMEOUT - 1));
  assign imem_addr = pc;
  assign cpu_in    = ir;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (go) state_nxt = FETCH;
        FETCH:   state_nxt = is_halt ? DONE : LOAD;
        LOAD:    state_nxt = ISSUE;
        ISSUE:   state_nxt = EXEC_LO;
        EXEC_LO: begin
          if (!cpu_w)   state_nxt = EXEC_HI;
          else if (tmo) state_nxt = ERROR;
        end
        EXEC_HI: begin
          if (cpu_w)    state_nxt = last ? DONE : FETCH;
          else if (tmo) state_nxt = ERROR;
        end
        DONE:    if (go) state_nxt = FETCH;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: pc, icount, ir and the wait-phase timeout counter; all hold on abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      icount <= '0;
      ir     <= '0;
      tcnt   <= '0;
    end else if (!abort) begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            pc     <= '0;
            icount <= '0;
          end
        end
        FETCH:   if (!is_halt) ir <= imem_data;
        ISSUE:   tcnt <= '0;
        EXEC_LO: begin
          if (!cpu_w) tcnt <= '0;
          else        tcnt <= tcnt + 1'b1;
        end
        EXEC_HI: begin
          if (cpu_w) begin
            pc   <= pc + 1'b1;
            tcnt <= '0;
            if (icount != '1) icount <= icount + 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state only, so an asynchronous reset drops strobes at once
  always_comb begin
    cpu_load = (state == LOAD);
    cpu_s    = (state == ISSUE);
    busy     = !((state == IDLE) || (state == DONE) || (state == ERROR));
    done     = (state == DONE);
    error    = (state == ERROR);
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected CPU loads and
// run outcomes into queues; a negedge monitor pops and compares them.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic        cpu_s;
  logic        cpu_w = 1'b1;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  pc;
  logic [15:0] icount;

  // second instance with a 2-bit program counter
  logic        start2;
  logic        abort2;
  logic [1:0]  imem_addr2;
  logic [15:0] imem_data2;
  logic [15:0] cpu_in2;
  logic        cpu_load2;
  logic        cpu_s2;
  logic        cpu_w2 = 1'b1;
  logic        busy2;
  logic        done2;
  logic        error2;
  logic [1:0]  pc2;
  logic [15:0] icount2;

  logic [15:0] mem  [256];
  logic [15:0] mem2 [4];

  int npass = 0;
  int nchk  = 0;

  logic [15:0] exp_load [$];
  logic [24:0] exp_done [$];   // {error, pc, icount}

  instr_sequencer #(.ADDR_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_w(cpu_w),
    .busy(busy), .done(done), .error(error), .pc(pc), .icount(icount)
  );

  instr_sequencer #(.ADDR_W(2), .TIMEOUT(64)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .imem_addr(imem_addr2), .imem_data(imem_data2),
    .cpu_in(cpu_in2), .cpu_load(cpu_load2), .cpu_s(cpu_s2), .cpu_w(cpu_w2),
    .busy(busy2), .done(done2), .error(error2), .pc(pc2), .icount(icount2)
  );

  assign imem_data  = mem[imem_addr];
  assign imem_data2 = mem2[imem_addr2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // CPU model: 3-cycle execute with cpu_w low; hang=1 ignores cpu_s.
  // Toy decode: Dxyy -> R[x]=yy; Ax.. -> R[b7:5] = R[b11:8] + R[b3:0].
  logic        hang = 1'b0;
  int          cnt = 0;
  logic [15:0] cir = '0;
  logic [15:0] r [16];

  always @(posedge clk) begin
    if (cpu_load) cir <= cpu_in;
    if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        cpu_w <= 1'b1;
        case (cir[15:12])
          4'hD: r[cir[11:8]] <= {8'h00, cir[7:0]};
          4'hA: r[{1'b0, cir[7:5]}] <= r[cir[11:8]] + r[cir[3:0]];
          default: ;
        endcase
      end
    end else if (cpu_s && !hang) begin
      cnt   <= 3;
      cpu_w <= 1'b0;
    end
  end

  int cnt2   = 0;
  int loads2 = 0;
  always @(posedge clk) begin
    if (cpu_load2) loads2 <= loads2 + 1;
    if (cnt2 > 0) begin
      cnt2 <= cnt2 - 1;
      if (cnt2 == 1) cpu_w2 <= 1'b1;
    end else if (cpu_s2) begin
      cnt2   <= 3;
      cpu_w2 <= 1'b0;
    end
  end

  // Monitor: pops expected loads and run outcomes as the DUT presents them
  logic done_q   = 1'b0;
  logic error_q  = 1'b0;
  logic loaded   = 1'b0;
  logic [24:0] ed;
  always @(negedge clk) begin
    if (cpu_load) begin
      if (exp_load.size() == 0) chk("unexpected_load", {16'h0, cpu_in}, 32'hFFFF_FFFF);
      else chk("load_cpu_in", {16'h0, cpu_in}, {16'h0, exp_load.pop_front()});
      loaded = 1'b1;
    end
    if (cpu_s) begin
      chk("issue_order", {29'h0, loaded, cpu_load, cpu_w}, 32'h5);
      loaded = 1'b0;
    end
    if ((done && !done_q) || (error && !error_q)) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_end", {7'h0, error, pc, icount}, 32'hFFFF_FFFF);
      end else begin
        ed = exp_done.pop_front();
        chk("end_err_pc_icount", {7'h0, error, pc, icount}, {7'h0, ed});
      end
    end
    done_q  = done;
    error_q = error;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done || error) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("run_end_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_issue(input int count, input int limit);
    int ns = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cpu_s) ns++;
      if (ns == count) break;
    end
    if (ns != count) chk("issue_timeout", ns, count);
  endtask

  int n;

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    for (int unsigned i = 0; i < 256; i++) mem[i] = 16'hE000;
    for (int unsigned i = 0; i < 16; i++) r[i] = '0;
    mem2[0] = 16'hD001; mem2[1] = 16'hD102; mem2[2] = 16'hD203; mem2[3] = 16'hD304;

    // reset state (asynchronous, before any clock edge)
    #1;
    chk("rst_flags", {28'h0, busy, done, error, cpu_load}, 32'h0);
    chk("rst_cpu_s", {31'h0, cpu_s}, 32'h0);
    chk("rst_pc_icount", {8'h0, pc, icount}, 32'h0);
    chk("rst_cpu_in", {16'h0, cpu_in}, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {31'h0, busy}, 32'h0);

    // single MOV then HALT
    mem[0] = 16'hD003;
    mem[1] = 16'hE000;
    exp_load.push_back(16'hD003);
    exp_done.push_back({1'b0, 8'd1, 16'd1});
    pulse_start();
    wait_end(200);
    chk("t1_r0", {16'h0, r[0]}, 32'd3);

    // three instructions, restart from DONE, start held while busy
    mem[1] = 16'hD104;
    mem[2] = 16'hA081;
    mem[3] = 16'hE000;
    exp_load.push_back(16'hD003);
    exp_load.push_back(16'hD104);
    exp_load.push_back(16'hA081);
    exp_done.push_back({1'b0, 8'd3, 16'd3});
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_end(300);
    chk("t2_r1", {16'h0, r[1]}, 32'd4);
    chk("t2_r4", {16'h0, r[4]}, 32'd7);

    // abort from DONE: back to IDLE with pc/icount held
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_flags", {29'h0, busy, done, error}, 32'h0);
    chk("abort_hold", {8'h0, pc, icount}, {8'h0, 8'd3, 16'd3});

    // abort and start together in IDLE: nothing starts
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_start_idle", {29'h0, busy, done, error}, 32'h0);

    // CPU never drops cpu_w: timeout into ERROR
    hang = 1'b1;
    exp_load.push_back(16'hD003);
    exp_done.push_back({1'b1, 8'd0, 16'd0});
    pulse_start();
    wait_issue(1, 50);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (error) break;
    end
    chk("timeout_cycles", n, 65);
    chk("error_busy", {30'h0, error, busy}, 32'h2);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("error_sticky", {30'h0, error, busy}, 32'h2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("error_abort", {30'h0, error, busy}, 32'h0);
    hang = 1'b0;
    repeat (2) @(negedge clk);

    // reset during EXEC_HI of the second instruction
    mem[2] = 16'hE000;
    exp_load.push_back(16'hD003);
    exp_load.push_back(16'hD104);
    pulse_start();
    wait_issue(2, 100);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_exec_hi", {22'h0, busy, cpu_w, pc}, {22'h0, 1'b1, 1'b0, 8'd1});
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_flags", {29'h0, busy, cpu_s, cpu_load}, 32'h0);
    chk("mid_rst_pc_icount", {8'h0, pc, icount}, 32'h0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_load.push_back(16'hD003);
    exp_load.push_back(16'hD104);
    exp_done.push_back({1'b0, 8'd2, 16'd2});
    pulse_start();
    wait_end(300);

    // 2-bit pc: four instructions, wrap to 0, DONE
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done2 || error2) break;
      n++;
    end
    chk("wrap_done_error", {30'h0, done2, error2}, 32'h2);
    chk("wrap_pc_icount", {14'h0, pc2, icount2}, {14'h0, 2'd0, 16'd4});
    chk("wrap_loads", loads2, 4);

    repeat (3) @(negedge clk);
    chk("load_queue_empty", exp_load.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
